// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of {pc, inst, sideband} between
// instruction fetch and the decoder, with valid/ready on both sides, a
// synchronous flush for branch redirects and NOP bubbles while empty.
// All head outputs are registered and sourced from storage or the write path
// of the same edge, so there is no combinational input-to-output path.
module if_id_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned SB_W   = 1,
    parameter int unsigned DEPTH  = 2,
    parameter logic [DATA_W-1:0] NOP = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       flushIn,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [PC_W-1:0]            pcIn,
    input  logic [DATA_W-1:0]          dataIn,
    input  logic [SB_W-1:0]            sbIn,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [PC_W-1:0]            pcOut,
    output logic [DATA_W-1:0]          dataOut,
    output logic [SB_W-1:0]            sbOut,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       dropErr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // storage (intentionally not reset)
    logic [PC_W-1:0]   pc_mem_r   [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [SB_W-1:0]   sb_mem_r   [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic [PC_W-1:0]   pc_out_r;
    logic [DATA_W-1:0] data_out_r;
    logic [SB_W-1:0]   sb_out_r;
    logic [PC_W-1:0]   last_pc_r;
    logic              drop_err_r;

    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [PTR_W-1:0]  next_idx_s;
    logic [PC_W-1:0]   head_pc_s;
    logic [DATA_W-1:0] head_data_s;
    logic [SB_W-1:0]   head_sb_s;

    assign push_s = inValid & in_ready_r & ~flushIn;
    assign pop_s  = out_valid_r & outReady & ~flushIn;

    assign inReady  = in_ready_r;
    assign outValid = out_valid_r;
    assign pcOut    = pc_out_r;
    assign dataOut  = data_out_r;
    assign sbOut    = sb_out_r;
    assign count    = count_r;
    assign dropErr  = drop_err_r;

    // next occupancy from the push/pop combination
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // select the entry that will be at the head after this edge; if it is
    // the slot being written now, take it from the write data
    always_comb begin
        next_idx_s  = rd_ptr_r;
        head_pc_s   = {PC_W{1'b0}};
        head_data_s = {DATA_W{1'b0}};
        head_sb_s   = {SB_W{1'b0}};
        if (pop_s) begin
            next_idx_s = rd_ptr_r + PTR_W'(1);
        end else begin
            next_idx_s = rd_ptr_r;
        end
        if (push_s && (next_idx_s == wr_ptr_r)) begin
            head_pc_s   = pcIn;
            head_data_s = dataIn;
            head_sb_s   = sbIn;
        end else begin
            head_pc_s   = pc_mem_r[next_idx_s];
            head_data_s = data_mem_r[next_idx_s];
            head_sb_s   = sb_mem_r[next_idx_s];
        end
    end

    // write the tail entry on an accepted push
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= pcIn;
            data_mem_r[wr_ptr_r] <= dataIn;
            sb_mem_r[wr_ptr_r]   <= sbIn;
        end
    end

    // pointers, occupancy, handshake flags and registered head outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            pc_out_r    <= {PC_W{1'b0}};
            data_out_r  <= NOP;
            sb_out_r    <= {SB_W{1'b0}};
            last_pc_r   <= {PC_W{1'b0}};
        end else if (flushIn) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            pc_out_r    <= last_pc_r;
            data_out_r  <= NOP;
            sb_out_r    <= {SB_W{1'b0}};
        end else begin
            rd_ptr_r    <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            wr_ptr_r    <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            in_ready_r  <= (count_nxt_s < DEPTH_C);
            last_pc_r   <= pop_s ? pc_out_r : last_pc_r;
            if (count_nxt_s != {CNT_W{1'b0}}) begin
                pc_out_r   <= head_pc_s;
                data_out_r <= head_data_s;
                sb_out_r   <= head_sb_s;
            end else begin
                pc_out_r   <= pop_s ? pc_out_r : last_pc_r;
                data_out_r <= NOP;
                sb_out_r   <= {SB_W{1'b0}};
            end
        end
    end

    // sticky overflow flag: a fetch offered while the queue cannot accept
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drop_err_r <= 1'b0;
        end else if (inValid && !in_ready_r) begin
            drop_err_r <= 1'b1;
        end else begin
            drop_err_r <= drop_err_r;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a random
// handshake run, all against a queue-based reference model.
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        sb;
    } ent_t;

    logic        clk;
    logic        resetN;
    logic        flushIn;
    logic        inValid;
    logic        inReady;
    logic [31:0] pcIn;
    logic [31:0] dataIn;
    logic [0:0]  sbIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] pcOut;
    logic [31:0] dataOut;
    logic [0:0]  sbOut;
    logic [1:0]  count;
    logic        dropErr;

    int checks = 0;
    int errors = 0;

    ent_t        q[$];
    logic        drop_exp;
    logic [31:0] last_pc;

    if_id_queue #(.DATA_W(32), .PC_W(32), .SB_W(1), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk(clk), .resetN(resetN), .flushIn(flushIn),
        .inValid(inValid), .inReady(inReady),
        .pcIn(pcIn), .dataIn(dataIn), .sbIn(sbIn),
        .outValid(outValid), .outReady(outReady),
        .pcOut(pcOut), .dataOut(dataOut), .sbOut(sbOut),
        .count(count), .dropErr(dropErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        drop_exp = 1'b0;
        last_pc  = 32'h0;
    endtask

    task automatic compare_outputs();
        check("count", 64'(count), 64'(q.size()));
        check("out_valid", 64'(outValid), 64'(q.size() != 0));
        check("in_ready", 64'(inReady), 64'(q.size() < DEPTH));
        check("drop_err", 64'(dropErr), 64'(drop_exp));
        if (q.size() != 0) begin
            check("head_pc", 64'(pcOut), 64'(q[0].pc));
            check("head_data", 64'(dataOut), 64'(q[0].inst));
            check("head_sb", 64'(sbOut), 64'(q[0].sb));
        end else begin
            check("empty_data", 64'(dataOut), 64'(NOP));
            check("empty_sb", 64'(sbOut), 64'h0);
            check("empty_pc", 64'(pcOut), 64'(last_pc));
        end
    endtask

    // called just after a falling edge: check, drive, update model, advance
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] d,
                        input logic sb, input logic ordy, input logic fl);
        logic push;
        logic pop;
        ent_t e;
        compare_outputs();
        inValid  = iv;
        pcIn     = pc;
        dataIn   = d;
        sbIn     = sb;
        outReady = ordy;
        flushIn  = fl;
        push = iv && (q.size() < DEPTH) && !fl;
        pop  = (q.size() != 0) && ordy && !fl;
        if (iv && !(q.size() < DEPTH)) drop_exp = 1'b1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) begin
                last_pc = q[0].pc;
                void'(q.pop_front());
            end
            if (push) begin
                e.pc = pc; e.inst = d; e.sb = sb;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; flushIn = 1'b0; inValid = 1'b0; outReady = 1'b0;
        pcIn = 32'h0; dataIn = 32'h0; sbIn = 1'b0;
        model_reset();
        do_reset();
        compare_outputs();

        // 1: single push, visible the next cycle
        step(1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0, 1'b0);
        check("t1_count", 64'(count), 64'd1);
        check("t1_data", 64'(dataOut), 64'h00500093);
        check("t1_pc", 64'(pcOut), 64'h100);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        // 2: three back-to-back pushes into a 2-deep queue, then drain
        do_reset();
        step(1'b1, 32'h200, 32'h11111111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'h22222222, 1'b1, 1'b0, 1'b0);
        check("t2_in_ready_full", 64'(inReady), 64'd0);
        step(1'b1, 32'h208, 32'h33333333, 1'b0, 1'b0, 1'b0);
        check("t2_drop", 64'(dropErr), 64'd1);
        check("t2_first", 64'(dataOut), 64'h11111111);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("t2_second", 64'(dataOut), 64'h22222222);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        // 3: steady push+pop at count 1 across pointer wrap
        do_reset();
        step(1'b1, 32'h300, 32'hA0000000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'h300 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'(i), 1'b1, 1'b0);
        end
        check("t3_count", 64'(count), 64'd1);
        check("t3_nodrop", 64'(dropErr), 64'd0);
        idle();

        // 4: flush of a full queue wins over a concurrent push
        step(1'b1, 32'h400, 32'hB0000001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h404, 32'hB0000002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h408, 32'hB0000003, 1'b1, 1'b1, 1'b1);
        check("t4_count", 64'(count), 64'd0);
        check("t4_data", 64'(dataOut), 64'(NOP));
        idle();

        // 5: asynchronous reset mid-stream, checked between edges
        step(1'b1, 32'h500, 32'hC0000001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h504, 32'hC0000002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h508, 32'hC0000003, 1'b0, 1'b0, 1'b0);
        #2;
        resetN = 1'b0;
        #1;
        check("t5_count", 64'(count), 64'd0);
        check("t5_valid", 64'(outValid), 64'd0);
        check("t5_data", 64'(dataOut), 64'(NOP));
        check("t5_pc", 64'(pcOut), 64'h0);
        check("t5_drop", 64'(dropErr), 64'd0);
        @(negedge clk);
        model_reset();
        resetN = 1'b1;
        idle();

        // 6: random handshakes against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 9) < 7), $urandom, $urandom, 1'($urandom),
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 99) < 2));
        end
        compare_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
